// File: rtl/cv_lzc_seq.sv
// Sequential leading/trailing zero counter: scans the latched operand one CHUNK per cycle
// from the counting end and stops at the first chunk that has a set bit.
module cv_lzc_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter bit          MODE  = 1'b1,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WIDTH-1:0]     in_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o,
  output logic                 busy_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CCW    = $clog2(CHUNK);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       op_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   resp_valid_q;
  logic                   busy_q;
  logic                   empty_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic [CHUNK-1:0]       chunk_sel [NCHUNK];
  logic [CHUNK-1:0]       chunk;
  logic [CCW-1:0]         chunk_cnt;
  logic                   chunk_nz;
  logic                   last_idx;
  logic [CNT_WIDTH-1:0]   scan_cnt;

  // Chunk 0 always sits at the counting end, so the scan index only ever increments.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    if (MODE) begin : g_msb
      assign chunk_sel[g] = op_q[WIDTH-1-g*CHUNK -: CHUNK];
    end else begin : g_lsb
      assign chunk_sel[g] = op_q[g*CHUNK +: CHUNK];
    end
  end

  assign chunk = chunk_sel[idx_q];

  // Priority search; the last match in loop order wins, giving the bit nearest the counting end.
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (MODE) begin
        if (chunk[i]) chunk_cnt = CCW'(CHUNK - 1 - i);
      end else begin
        if (chunk[CHUNK-1-i]) chunk_cnt = CCW'(CHUNK - 1 - i);
      end
    end
  end

  assign chunk_nz = |chunk;
  assign last_idx = (idx_q == IDX_W'(NCHUNK - 1));
  assign scan_cnt = CNT_WIDTH'(32'(idx_q) * CHUNK + 32'(chunk_cnt));

  assign req_ready_o  = (state_q == StIdle) && !flush_i && !rst_i;
  assign resp_valid_o = resp_valid_q;
  assign busy_o       = busy_q;
  assign cnt_o        = cnt_q;
  assign empty_o      = empty_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      op_q         <= '0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      empty_q      <= 1'b0;
    end else if (flush_i) begin
      // Result registers keep their last value; a pending response is simply dropped.
      state_q      <= StIdle;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            op_q    <= in_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (chunk_nz) begin
            cnt_q        <= scan_cnt;
            empty_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else if (last_idx) begin
            cnt_q        <= CNT_WIDTH'(WIDTH - 1);
            empty_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            idx_q        <= '0;
            state_q      <= StIdle;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv_lzc_seq.sv
// Bench for cv_lzc_seq: one leading-zero and one trailing-zero instance, each checked
// against a bit-scan reference model on directed and random operands.
module tb_cv_lzc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  flush, req_valid, resp_ready;
  logic [63:0] in_v [2];
  logic [1:0]  req_ready, resp_valid, empty, busy;
  logic [5:0]  cnt [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0: trailing zeros (MODE=0); index 1: leading zeros (MODE=1).
  cv_lzc_seq #(.WIDTH(64), .CHUNK(16), .MODE(1'b0)) u_tz (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .req_valid_i(req_valid[0]),
    .req_ready_o(req_ready[0]), .in_i(in_v[0]), .resp_valid_o(resp_valid[0]),
    .resp_ready_i(resp_ready[0]), .cnt_o(cnt[0]), .empty_o(empty[0]), .busy_o(busy[0])
  );

  cv_lzc_seq #(.WIDTH(64), .CHUNK(16), .MODE(1'b1)) u_lz (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .req_valid_i(req_valid[1]),
    .req_ready_o(req_ready[1]), .in_i(in_v[1]), .resp_valid_o(resp_valid[1]),
    .resp_ready_i(resp_ready[1]), .cnt_o(cnt[1]), .empty_o(empty[1]), .busy_o(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain bit scan, latency = chunks examined.
  function automatic void model(input bit mode, input logic [63:0] v,
                                output int c, output bit e, output int lat);
    e = (v == 64'd0);
    c = 63;
    if (!e) begin
      if (mode) begin
        for (int i = 63; i >= 0; i--) if (v[i]) begin c = 63 - i; break; end
      end else begin
        for (int i = 0; i < 64; i++) if (v[i]) begin c = i; break; end
      end
    end
    lat = e ? 4 : c / 16 + 1;
  endfunction

  task automatic do_op(input int m, input logic [63:0] v, input int hold, input bit scramble);
    int c, lat, n;
    bit e;
    model(m[0], v, c, e, lat);
    checks++;
    if (req_ready[m] !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready m=%0d got=%b want=1", m, req_ready[m]);
    end
    req_valid[m] = 1'b1;
    in_v[m] = v;
    tick();
    req_valid[m] = 1'b0;
    in_v[m] = scramble ? '1 : {$urandom, $urandom};
    n = 0;
    while (resp_valid[m] !== 1'b1 && n < 8) begin
      checks++;
      if (busy[m] !== 1'b1 || req_ready[m] !== 1'b0) begin
        errors++;
        $display("FAIL scan_state m=%0d busy=%b ready=%b want busy=1 ready=0",
                 m, busy[m], req_ready[m]);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL latency m=%0d v=%h got=%0d want=%0d", m, v, n, lat);
    end
    checks++;
    if (cnt[m] !== 6'(c) || empty[m] !== e) begin
      errors++;
      $display("FAIL result m=%0d v=%h got cnt=%0d empty=%b want cnt=%0d empty=%b",
               m, v, cnt[m], empty[m], c, e);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (resp_valid[m] !== 1'b1 || cnt[m] !== 6'(c) || empty[m] !== e ||
          req_ready[m] !== 1'b0) begin
        errors++;
        $display("FAIL hold m=%0d cyc=%0d got valid=%b cnt=%0d empty=%b ready=%b want 1/%0d/%b/0",
                 m, i, resp_valid[m], cnt[m], empty[m], req_ready[m], c, e);
      end
    end
    resp_ready[m] = 1'b1;
    tick();
    resp_ready[m] = 1'b0;
    checks++;
    if (resp_valid[m] !== 1'b0 || busy[m] !== 1'b0 || req_ready[m] !== 1'b1 ||
        cnt[m] !== 6'(c) || empty[m] !== e) begin
      errors++;
      $display("FAIL handshake m=%0d got valid=%b busy=%b ready=%b cnt=%0d want 0/0/1/%0d",
               m, resp_valid[m], busy[m], req_ready[m], cnt[m], c);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (resp_valid[m] !== 1'b0 || busy[m] !== 1'b0 || cnt[m] !== 6'd0 ||
          empty[m] !== 1'b0 || req_ready[m] !== ~rst) begin
        errors++;
        $display("FAIL %s m=%0d got valid=%b busy=%b cnt=%0d empty=%b ready=%b want 0/0/0/0/%b",
                 tag, m, resp_valid[m], busy[m], cnt[m], empty[m], req_ready[m], ~rst);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("reset_state");
    rst = 1'b0;
    #1;
    check_reset_vals("reset_release");
  endtask

  task automatic test_directed();
    do_op(1, 64'h0000_0000_0001_0000, 0, 1'b0);
    do_op(1, 64'h0, 0, 1'b0);
    do_op(1, 64'h8000_0000_0000_0000, 0, 1'b0);
    do_op(0, 64'h0000_0000_0001_0000, 0, 1'b1);
    do_op(0, 64'h0, 1, 1'b1);
    do_op(0, 64'h8000_0000_0000_0000, 0, 1'b0);
  endtask

  task automatic test_hold();
    do_op(1, 64'h0000_0000_0001_0000, 5, 1'b0);
    do_op(0, 64'h0000_0400_0000_0000, 5, 1'b1);
  endtask

  task automatic test_flush();
    // Flush in the second scan cycle of an all-zero operand.
    req_valid[1] = 1'b1;
    in_v[1] = 64'h0;
    tick();
    req_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    #1;
    checks++;
    if (busy[1] !== 1'b0 || resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL flush_scan got busy=%b valid=%b ready=%b want 0/0/1",
               busy[1], resp_valid[1], req_ready[1]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (resp_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL flush_noresp cyc=%0d got valid=%b want 0", i, resp_valid[1]);
      end
    end
    do_op(1, 64'h1, 0, 1'b0);
    // Flush in idle blocks acceptance.
    flush[0] = 1'b1;
    req_valid[0] = 1'b1;
    in_v[0] = 64'h1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got=%b want 0", req_ready[0]);
    end
    tick();
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_accept got busy=%b want 0", busy[0]);
    end
    // Flush in RESP coincident with consumption.
    req_valid[1] = 1'b1;
    in_v[1] = 64'h8000_0000_0000_0000;
    tick();
    req_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    resp_ready[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    resp_ready[1] = 1'b0;
    #1;
    checks++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL flush_resp got valid=%b busy=%b ready=%b want 0/0/1",
               resp_valid[1], busy[1], req_ready[1]);
    end
    do_op(1, 64'h0000_0000_0000_00f0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    // Reset during SCAN, together with flush and a new request.
    req_valid[1] = 1'b1;
    in_v[1] = 64'h0;
    tick();
    tick();
    rst = 1'b1;
    flush = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready got=%b want 00", req_ready);
    end
    tick();
    check_reset_vals("rst_scan");
    rst = 1'b0;
    flush = 2'b00;
    req_valid = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
        errors++;
        $display("FAIL rst_scan_noresp cyc=%0d got valid=%b busy=%b want 0/0",
                 i, resp_valid[1], busy[1]);
      end
    end
    // Reset during RESP, with consumption, flush and request all asserted.
    req_valid[1] = 1'b1;
    in_v[1] = 64'h0000_0000_0001_0000;
    tick();
    req_valid[1] = 1'b0;
    n = 0;
    while (resp_valid[1] !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (resp_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp_reach got valid=%b want 1", resp_valid[1]);
    end
    rst = 1'b1;
    flush[1] = 1'b1;
    req_valid[1] = 1'b1;
    resp_ready[1] = 1'b1;
    tick();
    check_reset_vals("rst_resp");
    rst = 1'b0;
    flush[1] = 1'b0;
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    tick();
    checks++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp_after got valid=%b busy=%b want 0/0", resp_valid[1], busy[1]);
    end
  endtask

  task automatic test_random();
    logic [63:0] v;
    int m;
    for (int it = 0; it < 60; it++) begin
      m = int'($urandom_range(0, 1));
      v = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) v = 64'h0;
      else if (m == 1) v = v >> $urandom_range(0, 63);
      else v = v << $urandom_range(0, 63);
      do_op(m, v, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1, 64'h0000_0000_0000_0001, 0, 1'b0);
    do_op(1, 64'h0000_8000_0000_0000, 0, 1'b0);
    do_op(0, 64'h8000_0000_0000_0000, 0, 1'b1);
    do_op(0, 64'h0000_0000_0000_8000, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 2'b00;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    in_v[0] = '0;
    in_v[1] = '0;
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
